// File: rtl/jitter_profile_sequencer.sv
// rtl/jitter_profile_sequencer.sv - sums square/triangle DJ and LFSR RJ about a centre delay code
// Define JITTER_SEQ_RJ_EN to build in the random-jitter LFSR; otherwise rj is zero.
module jitter_profile_sequencer #(
  parameter int          CODE_W    = 6,
  parameter int          CENTER    = 32,
  parameter int          AMP_W     = 5,
  parameter int          PER_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [AMP_W-1:0]  cfg_amp,
  input  logic [PER_W-1:0]  cfg_per,
  input  logic [1:0]        cfg_rj_shift,
  input  logic              enable,
  output logic [CODE_W-1:0] dly_code,
  output logic              dly_valid,
  output logic              busy
);
  localparam int SUM_W = CODE_W + 2;
  localparam int DJ_W  = AMP_W + 1;
  localparam logic [CODE_W-1:0]       CENTER_C = CODE_W'(CENTER);
  localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(CENTER);
  localparam logic signed [DJ_W-1:0]  DJ_ONE   = DJ_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RET} state_t;
  state_t state;

  logic [1:0]              mode_q;
  logic [AMP_W-1:0]        amp_q;
  logic [PER_W-1:0]        per_q;
  logic [PER_W-1:0]        cnt;
  logic signed [DJ_W-1:0]  dj, dj_wrap, amp_s, ld_amp_s;
  logic                    dir_up, dir_wrap;
  logic signed [3:0]       rj;
  logic signed [SUM_W-1:0] sum;
  logic [CODE_W-1:0]       sat_code, step_code;
  logic [1:0]              ld_mode;
  logic                    run_step;

  assign run_step = (state == ST_RUN) && enable;
  assign amp_s    = {1'b0, amp_q};
  assign ld_mode  = cfg_valid ? cfg_mode : mode_q;
  assign ld_amp_s = cfg_valid ? {1'b0, cfg_amp} : amp_s;

`ifdef JITTER_SEQ_RJ_EN
  logic [15:0] lfsr;
  logic [1:0]  rj_shift_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      rj_shift_q <= '0;
    end else begin
      if (cfg_valid && cfg_ready) rj_shift_q <= cfg_rj_shift;
      // x^16+x^14+x^13+x^11+1, shifting toward bit 0
      if (run_step) lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  assign rj = $signed(lfsr[3:0]) >>> rj_shift_q;
`else
  logic rj_unused;
  assign rj_unused = ^{cfg_rj_shift, LFSR_SEED};
  assign rj        = '0;
`endif

  assign sum = CENTER_S + {{(SUM_W-DJ_W){dj[DJ_W-1]}}, dj} + {{(SUM_W-4){rj[3]}}, rj};

  always_comb begin
    if (sum[SUM_W-1])    sat_code = '0;
    else if (sum[CODE_W]) sat_code = '1;
    else                 sat_code = sum[CODE_W-1:0];
  end

  assign step_code = (dly_code > CENTER_C) ? dly_code - 1'b1 :
                     (dly_code < CENTER_C) ? dly_code + 1'b1 : dly_code;

  // Triangle reverses on the step that lands on +/-amp so |dj| never exceeds amp.
  always_comb begin
    dj_wrap  = '0;
    dir_wrap = dir_up;
    case (mode_q)
      2'd1: dj_wrap = -dj;
      2'd2: if (amp_q != '0) begin
        dj_wrap = dir_up ? dj + DJ_ONE : dj - DJ_ONE;
        if (dj_wrap == amp_s)       dir_wrap = 1'b0;
        else if (dj_wrap == -amp_s) dir_wrap = 1'b1;
      end
      default: dj_wrap = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dly_code  <= CENTER_C;
      dly_valid <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
      mode_q    <= '0;
      amp_q     <= '0;
      per_q     <= '0;
      cnt       <= '0;
      dj        <= '0;
      dir_up    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          dly_code <= CENTER_C;
          if (cfg_valid && cfg_ready) begin
            mode_q <= cfg_mode;
            amp_q  <= cfg_amp;
            per_q  <= cfg_per;
          end
          if (enable) begin
            state     <= ST_RUN;
            dly_valid <= 1'b1;
            busy      <= 1'b1;
            cfg_ready <= 1'b0;
            cnt       <= '0;
            dir_up    <= 1'b1;
            dj        <= (ld_mode == 2'd1) ? ld_amp_s : '0;
          end
        end
        ST_RUN: begin
          if (enable) begin
            dly_code <= sat_code;
            if (cnt == per_q) begin
              cnt    <= '0;
              dj     <= dj_wrap;
              dir_up <= dir_wrap;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state    <= ST_RET;
            dly_code <= step_code;
          end
        end
        ST_RET: begin
          if (enable) begin
            state <= ST_RUN;
          end else if (dly_code == CENTER_C) begin
            state     <= ST_IDLE;
            dly_valid <= 1'b0;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end else begin
            dly_code <= step_code;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jitter_profile_sequencer.sv
// tb/tb_jitter_profile_sequencer.sv - directed and random checks of jitter_profile_sequencer
// Reference model derives dj from run-cycle count and wrap count in closed form.
module tb_jitter_profile_sequencer;
  localparam int CENTER = 32;
`ifdef JITTER_SEQ_RJ_EN
  localparam bit RJ_ON = 1'b1;
`else
  localparam bit RJ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] cfg_mode = 2'd0;
  logic [1:0] cfg_rj_shift = 2'd0;
  logic [4:0] cfg_amp = 5'd0;
  logic [7:0] cfg_per = 8'd0;
  logic       cfg_ready, dly_valid, busy;
  logic [5:0] dly_code;

  int vectors = 0;
  int miscompares = 0;
  int m_state, m_code, m_k, m_mode, m_amp, m_per, m_shift, m_lfsr;

  jitter_profile_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_amp(cfg_amp), .cfg_per(cfg_per),
    .cfg_rj_shift(cfg_rj_shift), .enable(enable), .dly_code(dly_code),
    .dly_valid(dly_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // dj after w wraps: square alternates +/-amp, triangle is a 4*amp-period wave
  function automatic int dj_of(int k);
    int w, p;
    w = k / (m_per + 1);
    if (m_mode == 1) return (w % 2 == 0) ? m_amp : -m_amp;
    if (m_mode == 2 && m_amp != 0) begin
      p = w % (4 * m_amp);
      if (p <= m_amp) return p;
      if (p <= 3 * m_amp) return 2 * m_amp - p;
      return p - 4 * m_amp;
    end
    return 0;
  endfunction

  function automatic int rj_now();
    int v;
    v = m_lfsr & 15;
    if (v >= 8) v -= 16;
    return RJ_ON ? (v >>> m_shift) : 0;
  endfunction

  function automatic int toward(int c);
    if (c > CENTER) return c - 1;
    if (c < CENTER) return c + 1;
    return c;
  endfunction

  task automatic model_reset();
    m_state = 0; m_code = CENTER; m_k = 0;
    m_mode = 0; m_amp = 0; m_per = 0; m_shift = 0;
    m_lfsr = 32'hACE1;
  endtask

  task automatic model_edge();
    int s;
    case (m_state)
      0: begin
        m_code = CENTER;
        if (cfg_valid) begin
          m_mode = cfg_mode; m_amp = cfg_amp; m_per = cfg_per; m_shift = cfg_rj_shift;
        end
        if (enable) begin
          m_state = 1;
          m_k = 0;
        end
      end
      1: begin
        if (enable) begin
          s = CENTER + dj_of(m_k) + rj_now();
          m_code = (s < 0) ? 0 : ((s > 63) ? 63 : s);
          m_k++;
          m_lfsr = (m_lfsr >> 1) | (((m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1) << 15);
        end else begin
          m_state = 2;
          m_code = toward(m_code);
        end
      end
      default: begin
        if (enable) m_state = 1;
        else if (m_code == CENTER) m_state = 0;
        else m_code = toward(m_code);
      end
    endcase
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".dly_code"}, 32'(dly_code), m_code);
    check({tag, ".dly_valid"}, 32'(dly_valid), (m_state != 0) ? 1 : 0);
    check({tag, ".busy"}, 32'(busy), (m_state != 0) ? 1 : 0);
    check({tag, ".cfg_ready"}, 32'(cfg_ready), (m_state == 0) ? 1 : 0);
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drain(string tag);
    for (int i = 0; i < 80 && m_state != 0; i++) step(tag);
    step({tag, "_idle"});
  endtask

  initial begin
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // square amp4 per3, config and enable in the same idle cycle
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_amp = 5'd4; cfg_per = 8'd3; cfg_rj_shift = 2'd0;
    enable = 1'b1;
    step("square");
    cfg_valid = 1'b0;
    repeat (18) step("square");
    for (int i = 0; i < 16 && m_code != 36; i++) step("square_to36");
    enable = 1'b0;
    drain("return36");

    // triangle amp2 per0, config attempt while running, pause and resume
    cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_amp = 5'd2; cfg_per = 8'd0; enable = 1'b1;
    step("tri");
    cfg_valid = 1'b0;
    repeat (12) step("tri");
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_amp = 5'd20; cfg_per = 8'd5; cfg_rj_shift = 2'd3;
    repeat (4) step("cfg_in_run");
    cfg_valid = 1'b0;
    enable = 1'b0;
    repeat (2) step("tri_pause");
    enable = 1'b1;
    repeat (8) step("tri_resume");
    enable = 1'b0;
    drain("tri_ret");

    // saturation with amp31
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_amp = 5'd31; cfg_per = 8'd1; enable = 1'b1;
    step("sat");
    cfg_valid = 1'b0;
    repeat (10) step("sat");
    enable = 1'b0;
    drain("sat_ret");

    // async reset mid-run, then shadow config must be gone
    cfg_valid = 1'b1; cfg_mode = 2'd1; cfg_amp = 5'd7; cfg_per = 8'd2; enable = 1'b1;
    step("pre_rst");
    cfg_valid = 1'b0;
    repeat (5) step("pre_rst");
    #3 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) step("shadow_lost");
    enable = 1'b0;
    drain("shadow_ret");

    for (int e = 0; e < 10; e++) begin
      cfg_valid = 1'b1;
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_amp = 5'($urandom_range(0, 31));
      cfg_per = 8'($urandom_range(0, 6));
      cfg_rj_shift = 2'($urandom_range(0, 3));
      enable = 1'($urandom_range(0, 1));
      step("rnd_cfg");
      for (int i = 0; i < 40; i++) begin
        enable = ($urandom_range(0, 9) < 8);
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_mode = 2'($urandom_range(0, 3));
        cfg_amp = 5'($urandom_range(0, 31));
        cfg_per = 8'($urandom_range(0, 6));
        cfg_rj_shift = 2'($urandom_range(0, 3));
        step("rnd");
      end
      cfg_valid = 1'b0;
      enable = 1'b0;
      drain("rnd_ret");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
